urv_exec_divider: RTL and testbench

URV_EXEC_DIVIDER -- requirements
Module: urv_exec_divider

---
 rtl/urv_defs.sv | 23 ++
 rtl/urv_div_step.sv | 24 ++
 rtl/urv_exec_divider.sv | 163 ++++++++++++++++
 tb/tb_urv_exec_divider.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_defs.sv
// Shared definitions for the execute-stage divider: function codes and FSM states.
package urv_defs;

  localparam logic [2:0] FUN_DIV  = 3'b100;
  localparam logic [2:0] FUN_DIVU = 3'b101;
  localparam logic [2:0] FUN_REM  = 3'b110;
  localparam logic [2:0] FUN_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic fun_is_signed(input logic [2:0] fun);
    return (fun == FUN_DIV) || (fun == FUN_REM);
  endfunction

  function automatic logic fun_is_rem(input logic [2:0] fun);
    return (fun == FUN_REM) || (fun == FUN_REMU);
  endfunction

endpackage

// File: rtl/urv_div_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit,
// subtract the divisor when it fits, and shift the resulting quotient bit in.
module urv_div_step #(
  parameter int g_width = 32
) (
  input  logic [g_width:0]   rem_i,
  input  logic [g_width-1:0] quo_i,
  input  logic [g_width-1:0] divisor_i,
  output logic [g_width:0]   rem_o,
  output logic [g_width-1:0] quo_o
);

  logic [g_width:0] shifted;
  logic [g_width:0] divisor_ext;
  logic             fits;

  assign shifted     = {rem_i[g_width-1:0], quo_i[g_width-1]};
  assign divisor_ext = {1'b0, divisor_i};
  // A set top bit means the true shifted value exceeds any divisor.
  assign fits        = rem_i[g_width] || (shifted >= divisor_ext);
  assign rem_o       = fits ? (shifted - divisor_ext) : shifted;
  assign quo_o       = {quo_i[g_width-2:0], fits};

endmodule

// File: rtl/urv_exec_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU in the execute stage.
// States: IDLE wait for op | BUSY iterate, stall pipeline | DONE hold result until unstalled.
module urv_exec_divider
  import urv_defs::*;
#(
  parameter int g_width          = 32,
  parameter int g_bits_per_cycle = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               x_stall_i,
  input  logic               x_kill_i,
  input  logic               d_valid_i,
  input  logic               d_is_divide_i,
  input  logic [2:0]         d_fun_i,
  input  logic [g_width-1:0] d_rs1_i,
  input  logic [g_width-1:0] d_rs2_i,
  output logic               x_stall_req_o,
  output logic [g_width-1:0] x_rd_o,
  output logic               x_rd_valid_o
);

  localparam int N_ITER = g_width / g_bits_per_cycle;
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N_ITER - 1);
  localparam logic [g_width-1:0] MOST_NEG = {1'b1, {(g_width-1){1'b0}}};

  div_state_t         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [g_width:0]   rem_q;
  logic [g_width-1:0] quo_q;
  logic [g_width-1:0] divisor_q;
  logic [2:0]         fun_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [g_width-1:0] rd_q;
  logic               rd_valid_q;

  logic               accept_d;
  logic               signed_d;
  logic               rs1_neg_d;
  logic               rs2_neg_d;
  logic               div_zero_d;
  logic               overflow_d;
  logic [g_width-1:0] rs1_mag_d;
  logic [g_width-1:0] rs2_mag_d;
  logic [g_width-1:0] early_rd_d;
  logic [g_width-1:0] quo_fin_d;
  logic [g_width-1:0] rem_fin_d;

  logic [g_width:0]   rem_chain [0:g_bits_per_cycle];
  logic [g_width-1:0] quo_chain [0:g_bits_per_cycle];

  assign accept_d   = (state_q == DIV_IDLE) && d_valid_i && d_is_divide_i && !x_kill_i;
  assign signed_d   = fun_is_signed(d_fun_i);
  assign rs1_neg_d  = signed_d && d_rs1_i[g_width-1];
  assign rs2_neg_d  = signed_d && d_rs2_i[g_width-1];
  assign rs1_mag_d  = rs1_neg_d ? -d_rs1_i : d_rs1_i;
  assign rs2_mag_d  = rs2_neg_d ? -d_rs2_i : d_rs2_i;
  assign div_zero_d = (d_rs2_i == '0);
  assign overflow_d = signed_d && (d_rs1_i == MOST_NEG) && (d_rs2_i == '1);

  // Results for the cases that bypass iteration.
  always_comb begin
    early_rd_d = '0;
    if (fun_is_rem(d_fun_i)) begin
      early_rd_d = div_zero_d ? d_rs1_i : '0;
    end else begin
      early_rd_d = div_zero_d ? '1 : d_rs1_i;
    end
  end

  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  for (genvar i = 0; i < g_bits_per_cycle; i++) begin : g_step
    urv_div_step #(
      .g_width(g_width)
    ) u_step (
      .rem_i    (rem_chain[i]),
      .quo_i    (quo_chain[i]),
      .divisor_i(divisor_q),
      .rem_o    (rem_chain[i+1]),
      .quo_o    (quo_chain[i+1])
    );
  end

  assign quo_fin_d = neg_quo_q ? -quo_chain[g_bits_per_cycle] : quo_chain[g_bits_per_cycle];
  assign rem_fin_d = neg_rem_q ? -rem_chain[g_bits_per_cycle][g_width-1:0]
                               :  rem_chain[g_bits_per_cycle][g_width-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      fun_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else if (x_kill_i) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (accept_d) begin
            fun_q     <= d_fun_i;
            neg_quo_q <= rs1_neg_d ^ rs2_neg_d;
            neg_rem_q <= rs1_neg_d;
            divisor_q <= rs2_mag_d;
            quo_q     <= rs1_mag_d;
            rem_q     <= '0;
            cnt_q     <= CNT_LAST;
            if (div_zero_d || overflow_d) begin
              state_q    <= DIV_DONE;
              rd_q       <= early_rd_d;
              rd_valid_q <= 1'b1;
            end else begin
              state_q <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          rem_q <= rem_chain[g_bits_per_cycle];
          quo_q <= quo_chain[g_bits_per_cycle];
          if (cnt_q == '0) begin
            state_q    <= DIV_DONE;
            rd_q       <= fun_is_rem(fun_q) ? rem_fin_d : quo_fin_d;
            rd_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIV_DONE: begin
          if (!x_stall_i) begin
            state_q    <= DIV_IDLE;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= DIV_IDLE;
          rd_q       <= '0;
          rd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational so the accepting cycle itself holds the pipeline.
  assign x_stall_req_o = !rst_i && !x_kill_i && (accept_d || (state_q == DIV_BUSY));
  assign x_rd_o        = rd_q;
  assign x_rd_valid_o  = rd_valid_q;

endmodule

// File: tb/tb_urv_exec_divider.sv
// Directed bench for urv_exec_divider: one 1-bit/cycle and one 4-bit/cycle instance
// checked against an arithmetic reference model and literal expectations.
module tb_urv_exec_divider;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_stall, x_kill;
  logic        d_valid1, d_valid4, d_is_div;
  logic [2:0]  d_fun;
  logic [31:0] rs1, rs2;
  logic        sreq1, sreq4, rdv1, rdv4;
  logic [31:0] rd1, rd4;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_res = '0;
  logic        exp_armed = 1'b0;

  always #5 clk = ~clk;

  urv_exec_divider dut1 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
    .d_valid_i(d_valid1), .d_is_divide_i(d_is_div), .d_fun_i(d_fun),
    .d_rs1_i(rs1), .d_rs2_i(rs2),
    .x_stall_req_o(sreq1), .x_rd_o(rd1), .x_rd_valid_o(rdv1)
  );

  urv_exec_divider #(.g_width(32), .g_bits_per_cycle(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
    .d_valid_i(d_valid4), .d_is_divide_i(d_is_div), .d_fun_i(d_fun),
    .d_rs1_i(rs1), .d_rs2_i(rs2),
    .x_stall_req_o(sreq4), .x_rd_o(rd4), .x_rd_valid_o(rdv4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: plain RISC-V division semantics.
  function automatic logic [31:0] ref_div(input logic [2:0] fun, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (fun)
      F_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REMU: return (b == 0) ? a : a % b;
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        else return 32'(sa / sb);
      end
      default: begin
        if (b == 0) return a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        else return 32'(sa % sb);
      end
    endcase
  endfunction

  function automatic logic sreq_of(input bit use4);
    return use4 ? sreq4 : sreq1;
  endfunction
  function automatic logic rdv_of(input bit use4);
    return use4 ? rdv4 : rdv1;
  endfunction
  function automatic logic [31:0] rd_of(input bit use4);
    return use4 ? rd4 : rd1;
  endfunction

  // Continuous output checker.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdv1) begin
        if (!exp_armed) check("dut1_unexpected_valid", {31'b0, rdv1}, 32'h0);
        else            check("dut1_result_vs_model", rd1, exp_res);
      end else begin
        check("dut1_rd_zero_when_invalid", rd1, 32'h0);
      end
      if (rdv4) begin
        if (!exp_armed) check("dut4_unexpected_valid", {31'b0, rdv4}, 32'h0);
        else            check("dut4_result_vs_model", rd4, exp_res);
      end else begin
        check("dut4_rd_zero_when_invalid", rd4, 32'h0);
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_op(input bit use4, input logic [2:0] fun, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit, input int exp_stall,
                       input int hold, input string name);
    int sc, vc;
    exp_res = ref_div(fun, a, b);
    check({name, "_model"}, exp_res, lit);
    exp_armed = 1'b1;
    x_stall   = (hold > 0);
    d_is_div  = 1'b1;
    d_fun     = fun;
    rs1       = a;
    rs2       = b;
    if (use4) d_valid4 = 1'b1;
    else      d_valid1 = 1'b1;
    sc = 0;
    @(negedge clk);
    while (sreq_of(use4) && sc < 200) begin
      sc++;
      @(posedge clk); #1;
      d_valid1 = 1'b0;
      d_valid4 = 1'b0;
      @(negedge clk);
    end
    d_valid1 = 1'b0;
    d_valid4 = 1'b0;
    check({name, "_stall_cycles"}, sc, exp_stall);
    check({name, "_valid"}, {31'b0, rdv_of(use4)}, 32'h1);
    check({name, "_rd"}, rd_of(use4), lit);
    vc = 0;
    while (rdv_of(use4) && vc < 50) begin
      vc++;
      @(posedge clk); #1;
      if (vc >= hold) x_stall = 1'b0;
      @(negedge clk);
    end
    check({name, "_valid_cycles"}, vc, hold + 1);
    exp_armed = 1'b0;
    d_is_div  = 1'b0;
    x_stall   = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; x_stall = 1'b0; x_kill = 1'b0;
    d_valid1 = 1'b0; d_valid4 = 1'b0; d_is_div = 1'b0;
    d_fun = F_DIVU; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall_req", {31'b0, sreq1}, 32'h0);
    check("reset_rd", rd1, 32'h0);
    check("reset_rd_valid", {31'b0, rdv1}, 32'h0);
    check("reset_rd_valid4", {31'b0, rdv4}, 32'h0);
    rst = 1'b0;

    // First op right after reset release also exercises accept on the first edge.
    do_op(0, F_DIVU, 32'd100, 32'd7, 32'd14, 33, 0, "divu_100_7");
    do_op(0, F_REMU, 32'd100, 32'd7, 32'd2, 33, 0, "remu_100_7");
    do_op(0, F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div_m7_2");
    do_op(0, F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem_m7_2");
    do_op(0, F_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0, "div_7_m2");
    do_op(0, F_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0, "rem_7_m2");
    do_op(0, F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_by_zero");
    do_op(0, F_REMU, 32'd5, 32'd0, 32'd5, 1, 0, "remu_by_zero");
    do_op(0, F_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, 0, "div_neg_by_zero");
    do_op(0, F_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0, "rem_neg_by_zero");
    do_op(0, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_overflow");
    do_op(0, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, "rem_overflow");
    do_op(0, F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 0, "divu_no_overflow");
    do_op(0, F_DIV,  32'h8000_0000, 32'd1, 32'h8000_0000, 33, 0, "div_minneg_1");
    do_op(0, F_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, 0, "div_m100_m7");
    do_op(0, F_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 0, "rem_m100_m7");
    do_op(0, F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0, "divu_max_1");
    do_op(0, F_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, 2, "remu_max_16_stall");

    // Not a divide: no accept.
    d_valid1 = 1'b1; d_is_div = 1'b0; d_fun = F_DIVU; rs1 = 32'd9; rs2 = 32'd3;
    @(negedge clk);
    check("non_divide_no_stall", {31'b0, sreq1}, 32'h0);
    @(posedge clk); #1;
    d_valid1 = 1'b0;

    // Kill in the same cycle as accept: nothing starts.
    d_valid1 = 1'b1; d_is_div = 1'b1; x_kill = 1'b1;
    @(negedge clk);
    check("kill_accept_stall", {31'b0, sreq1}, 32'h0);
    @(posedge clk); #1;
    d_valid1 = 1'b0; x_kill = 1'b0;
    @(negedge clk);
    check("kill_accept_not_busy", {31'b0, sreq1}, 32'h0);
    @(posedge clk); #1;

    // Kill in BUSY cycle 10.
    d_valid1 = 1'b1; d_is_div = 1'b1; d_fun = F_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    d_valid1 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    @(negedge clk);
    check("busy10_stall_before_kill", {31'b0, sreq1}, 32'h1);
    x_kill = 1'b1;
    #1;
    check("kill_busy_stall_req", {31'b0, sreq1}, 32'h0);
    @(posedge clk); #1;
    x_kill = 1'b0;
    @(negedge clk);
    check("kill_busy_idle_stall", {31'b0, sreq1}, 32'h0);
    check("kill_busy_no_valid", {31'b0, rdv1}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    d_is_div = 1'b0;
    do_op(0, F_DIVU, 32'd9, 32'd3, 32'd3, 33, 0, "divu_9_3_after_kill");

    // Four bits per cycle instance.
    do_op(1, F_DIVU, 32'd100, 32'd7, 32'd14, 9, 3, "q4_divu_100_7_hold3");
    do_op(1, F_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 9, 0, "q4_div_m100_7");
    do_op(1, F_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 9, 0, "q4_rem_m100_7");
    do_op(1, F_REMU, 32'd5, 32'd0, 32'd5, 1, 0, "q4_remu_by_zero");

    // Asynchronous reset mid-BUSY.
    d_valid1 = 1'b1; d_is_div = 1'b1; d_fun = F_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    d_valid1 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("busy_before_reset", {31'b0, sreq1}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_stall_req", {31'b0, sreq1}, 32'h0);
    check("async_rst_rd", rd1, 32'h0);
    check("async_rst_rd_valid", {31'b0, rdv1}, 32'h0);
    @(posedge clk); #1;
    d_is_div = 1'b0;
    rst = 1'b0;
    do_op(0, F_DIVU, 32'd100, 32'd7, 32'd14, 33, 0, "divu_after_async_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
